mdio_master_queued: RTL and testbench

Parametrised MDIO management master with command and response FIFOs, sitting on the Avalon register bus beside the Ethernet MAC and driving a PHY's MDC/MDIO pins. Software queues up to CMD_DEPTH raw 32-bit management frames. It drains read results from a response FIFO without polling each transaction. Additions over the single-frame master:

- Clause 45 frames
- runtime preamble suppression
- configurable MDC divider
- sticky overflow/underflow errors
- maskable interrupts

---
 rtl/mdio_master_queued.sv | 197 +++++++++++++++++++
 tb/tb_mdio_master_queued.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_queued.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_master_queued: queued MDIO master with command/response FIFOs        |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module mdio_master_queued #(
   parameter int CLK_DIV      = 10,
   parameter int CMD_DEPTH    = 8,
   parameter int RSP_DEPTH    = 8,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_read,
   input  logic        reg_write,
   input  logic [1:0]  reg_address,
   input  logic [31:0] reg_data_in,
   output logic        reg_read_valid,
   output logic [31:0] reg_data_out,
   output logic        irq,
   output logic        mdc,
   inout  wire         mdio
);
   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RSP_DEPTH);
   localparam int DW  = $clog2(2 * CLK_DIV);
   localparam logic [7:0]    c_cmd_full = 8'(CMD_DEPTH);
   localparam logic [7:0]    c_rsp_full = 8'(RSP_DEPTH);
   localparam logic [DW-1:0] c_half     = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] c_gap      = DW'(2 * CLK_DIV - 1);
   localparam logic [5:0]    c_pre_last = 6'(PREAMBLE_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_SHIFT, S_GAP} state_t;

   logic [31:0] cmd_mem [CMD_DEPTH];
   logic [15:0] rsp_mem [RSP_DEPTH];

   state_t          state_q, state_d;
   logic [CAW-1:0]  cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
   logic [RAW-1:0]  rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
   logic [7:0]      cmd_cnt_q, cmd_cnt_d, rsp_cnt_q, rsp_cnt_d;
   logic [3:0]      control_q, control_d;
   logic [2:0]      irqf_q, irqf_d;
   logic            ovf_q, ovf_d, unf_q, unf_d, rvalid_q, rvalid_d;
   logic [31:0]     rdata_q, rdata_d, sreg_q, sreg_d;
   logic [DW-1:0]   div_q, div_d;
   logic [5:0]      bit_q, bit_d;
   logic [15:0]     res_q, res_d;
   logic            mdc_q, mdc_d, is_rd_q, is_rd_d, oe_q, oe_d, dout_q, dout_d;

   logic w_cmd_full, w_cmd_empty, w_rsp_full, w_rsp_empty;
   logic w_data_wr, w_data_rd, w_cmd_push, w_cmd_ovf, w_rsp_pop, w_unf;
   logic w_cmd_pop, w_frame_done, w_idle_done, w_rsp_push, w_rsp_drop;
   logic w_rise, w_fall, w_head_rd, w_use_pre, w_stat_wr;
   logic [31:0] w_head;

   assign w_cmd_full  = (cmd_cnt_q == c_cmd_full);
   assign w_cmd_empty = (cmd_cnt_q == 8'd0);
   assign w_rsp_full  = (rsp_cnt_q == c_rsp_full);
   assign w_rsp_empty = (rsp_cnt_q == 8'd0);
   assign w_data_wr   = reg_write && (reg_address == 2'd0);
   assign w_data_rd   = reg_read  && (reg_address == 2'd0);
   assign w_stat_wr   = reg_write && (reg_address == 2'd1);
   assign w_cmd_push  = w_data_wr && !w_cmd_full;
   assign w_cmd_ovf   = w_data_wr && w_cmd_full;
   assign w_rsp_pop   = w_data_rd && !w_rsp_empty;
   assign w_unf       = w_data_rd && w_rsp_empty;
   assign w_head      = cmd_mem[cmd_rp_q];
   // Clause 22 read (01/10) or any Clause 45 read variant (00/1x)
   assign w_head_rd   = ((w_head[31:30] == 2'b01) && (w_head[29:28] == 2'b10)) ||
                        ((w_head[31:30] == 2'b00) && w_head[29]);
   assign w_use_pre   = (PREAMBLE_LEN != 0) && !control_q[3];
   assign w_rise      = (div_q == c_half) && !mdc_q;
   assign w_fall      = (div_q == c_half) && mdc_q;
   assign w_rsp_push  = w_frame_done && is_rd_q && !w_rsp_full;
   assign w_rsp_drop  = w_frame_done && is_rd_q && w_rsp_full;

   always_comb begin
      state_d = state_q; div_d = div_q; mdc_d = mdc_q; bit_d = bit_q;
      sreg_d = sreg_q; is_rd_d = is_rd_q; oe_d = oe_q; dout_d = dout_q; res_d = res_q;
      w_cmd_pop = 1'b0; w_frame_done = 1'b0; w_idle_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!w_cmd_empty) begin
               w_cmd_pop = 1'b1;
               sreg_d    = w_head;
               is_rd_d   = w_head_rd;
               div_d     = '0;
               mdc_d     = 1'b0;
               oe_d      = 1'b1;
               if (w_use_pre) begin
                  state_d = S_PRE;
                  bit_d   = c_pre_last;
                  dout_d  = 1'b1;
               end else begin
                  state_d = S_SHIFT;
                  bit_d   = 6'd31;
                  dout_d  = w_head[31];
               end
            end
         end
         S_PRE, S_SHIFT: begin
            div_d = (div_q == c_half) ? '0 : div_q + 1'b1;
            if (div_q == c_half) mdc_d = !mdc_q;
            if ((state_q == S_SHIFT) && w_rise && is_rd_q && (bit_q < 6'd16))
               res_d = {res_q[14:0], mdio};
            if (w_fall) begin
               if (state_q == S_PRE) begin
                  if (bit_q == 6'd0) begin
                     state_d = S_SHIFT;
                     bit_d   = 6'd31;
                     dout_d  = sreg_q[31];
                  end else begin
                     bit_d = bit_q - 6'd1;
                  end
               end else if (bit_q == 6'd0) begin
                  state_d      = S_GAP;
                  oe_d         = 1'b0;
                  div_d        = '0;
                  w_frame_done = 1'b1;
               end else begin
                  bit_d  = bit_q - 6'd1;
                  sreg_d = {sreg_q[30:0], 1'b0};
                  dout_d = sreg_q[30];
                  // read frames hand the line to the PHY from the turnaround bit on
                  oe_d   = !is_rd_q || (bit_q > 6'd18);
               end
            end
         end
         S_GAP: begin
            if (div_q == c_gap) begin
               state_d     = S_IDLE;
               div_d       = '0;
               w_idle_done = 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_wp_d  = w_cmd_push ? cmd_wp_q + 1'b1 : cmd_wp_q;
      cmd_rp_d  = w_cmd_pop  ? cmd_rp_q + 1'b1 : cmd_rp_q;
      cmd_cnt_d = cmd_cnt_q + {7'd0, w_cmd_push} - {7'd0, w_cmd_pop};
      rsp_wp_d  = w_rsp_push ? rsp_wp_q + 1'b1 : rsp_wp_q;
      rsp_rp_d  = w_rsp_pop  ? rsp_rp_q + 1'b1 : rsp_rp_q;
      rsp_cnt_d = rsp_cnt_q + {7'd0, w_rsp_push} - {7'd0, w_rsp_pop};
      control_d = (reg_write && (reg_address == 2'd2)) ? reg_data_in[3:0] : control_q;
      ovf_d     = (ovf_q && !w_stat_wr) || w_cmd_ovf || w_rsp_drop;
      unf_d     = (unf_q && !w_stat_wr) || w_unf;
      irqf_d    = irqf_q & ~((reg_write && (reg_address == 2'd3)) ? reg_data_in[2:0] : 3'b000);
      irqf_d    = irqf_d | {w_cmd_ovf || w_rsp_drop || w_unf, w_idle_done && w_cmd_empty, w_rsp_push};
      rvalid_d  = reg_read;
      rdata_d   = rdata_q;
      if (reg_read) begin
         case (reg_address)
            2'd0:    rdata_d = w_rsp_pop ? {16'h0, rsp_mem[rsp_rp_q]} : 32'h0;
            2'd1:    rdata_d = {8'h0, rsp_cnt_q, cmd_cnt_q, 3'b000, unf_q, ovf_q,
                                (state_q != S_IDLE), !w_rsp_empty, !w_cmd_full};
            2'd2:    rdata_d = {28'h0, control_q};
            default: rdata_d = {29'h0, irqf_q};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_cmd_push) cmd_mem[cmd_wp_q] <= reg_data_in;
      if (w_rsp_push) rsp_mem[rsp_wp_q] <= res_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;   cmd_wp_q <= '0;   cmd_rp_q <= '0;   cmd_cnt_q <= '0;
         rsp_wp_q <= '0;      rsp_rp_q <= '0;   rsp_cnt_q <= '0;  control_q <= '0;
         irqf_q <= '0;        ovf_q <= 1'b0;    unf_q <= 1'b0;    rvalid_q <= 1'b0;
         rdata_q <= '0;       sreg_q <= '0;     div_q <= '0;      bit_q <= '0;
         res_q <= '0;         mdc_q <= 1'b0;    is_rd_q <= 1'b0;  oe_q <= 1'b0;
         dout_q <= 1'b0;
      end else begin
         state_q <= state_d;  cmd_wp_q <= cmd_wp_d; cmd_rp_q <= cmd_rp_d; cmd_cnt_q <= cmd_cnt_d;
         rsp_wp_q <= rsp_wp_d; rsp_rp_q <= rsp_rp_d; rsp_cnt_q <= rsp_cnt_d; control_q <= control_d;
         irqf_q <= irqf_d;    ovf_q <= ovf_d;   unf_q <= unf_d;   rvalid_q <= rvalid_d;
         rdata_q <= rdata_d;  sreg_q <= sreg_d; div_q <= div_d;   bit_q <= bit_d;
         res_q <= res_d;      mdc_q <= mdc_d;   is_rd_q <= is_rd_d; oe_q <= oe_d;
         dout_q <= dout_d;
      end
   end

   assign mdc            = mdc_q;
   assign mdio           = oe_q ? dout_q : 1'bz;
   assign irq            = |(irqf_q & control_q[2:0]);
   assign reg_read_valid = rvalid_q;
   assign reg_data_out   = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mdio_master_queued.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdio_master_queued: directed bench with a behavioural PHY              |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_mdio_master_queued;
   localparam int CLK_DIV = 4;

   logic        clk = 1'b0, reset = 1'b1, reg_read = 1'b0, reg_write = 1'b0;
   logic [1:0]  reg_address = 2'd0;
   logic [31:0] reg_data_in = 32'd0;
   logic        reg_read_valid, irq, mdc;
   logic [31:0] reg_data_out;
   wire         mdio;
   logic        phy_oe = 1'b0, phy_out = 1'b0;

   int n_checks = 0, n_errors = 0;

   mdio_master_queued #(.CLK_DIV(CLK_DIV), .CMD_DEPTH(8), .RSP_DEPTH(8), .PREAMBLE_LEN(32)) dut (
      .clk(clk), .reset(reset), .reg_read(reg_read), .reg_write(reg_write),
      .reg_address(reg_address), .reg_data_in(reg_data_in),
      .reg_read_valid(reg_read_valid), .reg_data_out(reg_data_out),
      .irq(irq), .mdc(mdc), .mdio(mdio));

   assign mdio = phy_oe ? phy_out : 1'bz;
   always #5 clk = ~clk;

   // PHY model: frames are located by counting mdc rises past the known preamble
   int          pre_len = 32;
   int          cyc = 0, rise_total = 0, last_rise = 0, period = 0;
   int          frame_edge = 0, low_cnt = 0, rel17 = 0, drv18 = 0;
   logic        mdc_prev = 1'b0, rd = 1'b0;
   logic [31:0] sh = 32'd0;
   logic [15:0] phy_rd = 16'd0;
   logic [15:0] regs [32];
   logic [31:0] frames [$];

   always @(negedge clk) begin
      int idx;
      cyc++;
      if (mdc && !mdc_prev) begin
         rise_total++;
         period    = cyc - last_rise;
         last_rise = cyc;
         frame_edge++;
         if (frame_edge > pre_len) begin
            idx = 31 - (frame_edge - 1 - pre_len);
            if (idx >= 0) begin
               sh[idx] = mdio;
               if (idx == 28)
                  rd = ((sh[31:30] == 2'b01) && (sh[29:28] == 2'b10)) ||
                       ((sh[31:30] == 2'b00) && sh[29]);
               if (idx == 18) begin
                  phy_rd = regs[sh[22:18]];
                  if (rd && (mdio !== 1'bz)) drv18++;
               end
               if ((idx == 17) && rd && (mdio === 1'bz)) rel17++;
               if (idx == 0) begin
                  frames.push_back(sh);
                  if (sh[31:28] == 4'b0101) regs[sh[22:18]] = sh[15:0];
               end
            end
         end
      end
      if (!mdc && mdc_prev) begin
         idx    = 31 - (frame_edge - pre_len);
         phy_oe = rd && (frame_edge >= pre_len) && (idx >= 0) && (idx <= 15);
         if (phy_oe) phy_out = phy_rd[idx];
      end
      if (mdc) low_cnt = 0;
      else     low_cnt++;
      if (low_cnt == CLK_DIV + 2) begin
         frame_edge = 0;
         rd         = 1'b0;
         phy_oe     = 1'b0;
      end
      mdc_prev = mdc;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
      reg_address = a; reg_data_in = d; reg_write = 1'b1;
      @(negedge clk);
      reg_write = 1'b0;
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [31:0] d, output logic v);
      reg_address = a; reg_read = 1'b1;
      @(negedge clk);
      reg_read = 1'b0;
      d = reg_data_out;
      v = reg_read_valid;
   endtask

   task automatic wait_idle(input string tag, output logic busy_seen);
      logic [31:0] s;
      logic        v;
      int          n;
      busy_seen = 1'b0;
      n = 0;
      do begin
         reg_rd(2'd1, s, v);
         if (s[2]) busy_seen = 1'b1;
         n++;
      end while ((s[2] || (s[15:8] != 8'd0)) && (n < 20000));
      check({tag, "_timeout"}, 32'(n >= 20000), 32'd0);
   endtask

   initial begin
      logic [31:0] d, exp;
      logic        v, busy;
      int          base, fbase, rbase, dbase, n, bad;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1: reset state
      check("rvalid_idle", reg_read_valid, 1'b0);
      reg_rd(2'd1, d, v);
      check("rst_status", d, 32'h0000_0001);
      check("rst_rvalid", v, 1'b1);
      check("rst_irq", irq, 1'b0);
      bad = 0;
      repeat (100) begin
         if (mdc !== 1'b0 || mdio !== 1'bz) bad++;
         @(negedge clk);
      end
      check("rst_pins_quiet", bad, 0);

      // 2: Clause 22 write with preamble
      pre_len = 32; base = rise_total; fbase = frames.size();
      reg_wr(2'd0, 32'h5C72_BEEF);
      wait_idle("c22w", busy);
      check("c22w_busy_seen", busy, 1'b1);
      check("c22w_edges", rise_total - base, 64);
      check("c22w_period", period, 2 * CLK_DIV);
      check("c22w_frame", (frames.size() > fbase) ? frames[fbase] : 32'hDEAD_DEAD, 32'h5C72_BEEF);
      check("c22w_phy_reg", regs[28], 16'hBEEF);
      reg_rd(2'd3, d, v);
      check("c22w_irqreg", d, 32'h2);
      check("c22w_irq_pin", irq, 1'b0);
      reg_wr(2'd3, 32'h7);

      // 3: Clause 22 read
      rbase = rel17; dbase = drv18; fbase = frames.size();
      reg_wr(2'd0, 32'h6C70_0000);
      wait_idle("c22r", busy);
      reg_rd(2'd1, d, v);
      check("c22r_status", d, 32'h0001_0003);
      check("c22r_release17", rel17 - rbase, 1);
      check("c22r_drive18", drv18 - dbase, 1);
      check("c22r_hdr", (frames.size() > fbase) ? {18'd0, frames[fbase][31:18]} : 32'hDEAD_DEAD,
            32'h0000_1B1C);
      reg_rd(2'd3, d, v);
      check("c22r_irqreg", d, 32'h3);
      reg_wr(2'd2, 32'h1);
      check("c22r_irq_on", irq, 1'b1);
      reg_rd(2'd0, d, v);
      check("c22r_data", d, 32'h0000_BEEF);
      reg_wr(2'd3, 32'h1);
      check("c22r_irq_clr", irq, 1'b0);
      reg_wr(2'd3, 32'h7);

      // 4: overflow while the engine is busy with frame A
      reg_wr(2'd2, 32'h8);
      pre_len = 0; base = rise_total; fbase = frames.size();
      reg_wr(2'd0, 32'h5002_00AA);
      reg_address = 2'd0; reg_write = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         reg_data_in = 32'h5002_0000 + i;
         @(negedge clk);
      end
      reg_write = 1'b0;
      reg_rd(2'd1, d, v);
      check("ovf_status", d, 32'h0000_080C);
      wait_idle("ovf", busy);
      check("ovf_nframes", frames.size() - fbase, 9);
      for (int i = 0; i < 9; i++) begin
         exp = (i == 0) ? 32'h5002_00AA : 32'h5002_0000 + i;
         check($sformatf("ovf_frame%0d", i),
               (frames.size() > fbase + i) ? frames[fbase + i] : 32'hDEAD_DEAD, exp);
      end
      check("ovf_edges", rise_total - base, 9 * 32);
      reg_rd(2'd3, d, v);
      check("ovf_irqreg", d, 32'h6);
      reg_wr(2'd1, 32'h0);
      reg_rd(2'd1, d, v);
      check("ovf_cleared", d, 32'h0000_0001);
      reg_wr(2'd3, 32'h7);

      // 5: preamble suppressed Clause 45 read, then underflow
      base = rise_total; rbase = rel17;
      reg_wr(2'd0, 32'h3C72_0000);
      wait_idle("c45", busy);
      check("c45_edges", rise_total - base, 32);
      check("c45_release17", rel17 - rbase, 1);
      reg_rd(2'd1, d, v);
      check("c45_status", d, 32'h0001_0003);
      reg_rd(2'd0, d, v);
      check("c45_data", d, 32'h0000_BEEF);
      reg_rd(2'd0, d, v);
      check("unf_data", d, 32'h0);
      reg_rd(2'd1, d, v);
      check("unf_status", d, 32'h0000_0011);
      reg_rd(2'd3, d, v);
      check("unf_irqreg", d, 32'h7);

      // 6: asynchronous reset during a read frame
      reg_wr(2'd2, 32'h0);
      pre_len = 32; base = rise_total;
      reg_wr(2'd0, 32'h6C70_0000);
      n = 0;
      while ((rise_total - base < 40) && (n < 5000)) begin
         @(posedge clk);
         n++;
      end
      check("rst_mid_edge40", rise_total - base, 40);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_mdc", mdc, 1'b0);
      check("rst_mid_mdio_z", mdio === 1'bz, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      base = rise_total;
      repeat (400) @(negedge clk);
      check("rst_mid_no_mdc", rise_total - base, 0);
      reg_rd(2'd1, d, v);
      check("rst_mid_status", d, 32'h0000_0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
